// File: rtl/irq_gateway_pkg.sv
// -----------------------------------------------------------------------------
// irq_gateway_pkg
//   Shared types and helpers for the PLIC interrupt gateway bank.
//   - gw_state_e : per-source service state (idle / pending at PLIC / claimed)
//   - id_width() : width of a PLIC interrupt ID for a given number of sources
//                  (ID 0 is reserved for "no interrupt", so NumSources+1 codes)
// -----------------------------------------------------------------------------
package irq_gateway_pkg;

  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PENDING  = 2'd1,
    GW_INFLIGHT = 2'd2
  } gw_state_e;

  function automatic int unsigned id_width(input int unsigned num_sources);
    return $clog2(num_sources + 1);
  endfunction

endpackage

// File: rtl/irq_gateway_cell.sv
// -----------------------------------------------------------------------------
// irq_gateway_cell
//   Gateway for one interrupt source: synchroniser, rising-edge detect,
//   IDLE -> PENDING -> INFLIGHT service FSM, pending-edge counter and a sticky
//   overflow flag.
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   src_i          raw (asynchronous) interrupt wire
//   le_i           trigger mode: 1 = rising edge, 0 = level-high
//   claim_hit_i    PLIC core claimed this source's ID this cycle
//   complete_hit_i PLIC core completed this source's ID this cycle
//   ip_o           registered pending request to the PLIC core
//   overflow_o     sticky: an edge was dropped because the counter was full
// -----------------------------------------------------------------------------
module irq_gateway_cell
  import irq_gateway_pkg::*;
#(
  parameter int unsigned EdgeCntWidth = 4,
  parameter int unsigned SyncStages   = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic le_i,
  input  logic claim_hit_i,
  input  logic complete_hit_i,
  output logic ip_o,
  output logic overflow_o
);

  localparam logic [EdgeCntWidth-1:0] CntMax = '1;
  localparam logic [EdgeCntWidth-1:0] CntOne = {{(EdgeCntWidth-1){1'b0}}, 1'b1};

  logic [SyncStages-1:0]   sync_q, sync_d;
  logic                    sync_dly_q, sync_dly_d;
  gw_state_e               state_q, state_d;
  logic [EdgeCntWidth-1:0] cnt_q, cnt_d;
  logic                    ip_q, ip_d;
  logic                    ovf_q, ovf_d;

  logic level;
  logic rise;

  assign level = sync_q[SyncStages-1];
  assign rise  = level & ~sync_dly_q;

  // State register: every flop of the cell.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
      state_q    <= GW_IDLE;
      cnt_q      <= '0;
      ip_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ip_q       <= ip_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state logic: FSM, edge counter and overflow flag.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    sync_d     = {sync_q[SyncStages-2:0], src_i};
    sync_dly_d = level;
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      GW_IDLE: begin
        if (le_i) begin
          if (rise || (cnt_q != '0)) state_d = GW_PENDING;
          // A fresh edge while backlog exists: one consumed, one added -> no change.
          if ((cnt_q != '0) && !rise) cnt_d = cnt_q - CntOne;
        end else if (level) begin
          state_d = GW_PENDING;
        end
      end
      GW_PENDING: begin
        // A level drop here does not retract the request.
        if (claim_hit_i) state_d = GW_INFLIGHT;
      end
      GW_INFLIGHT: begin
        if (complete_hit_i) begin
          state_d = GW_IDLE;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = GW_IDLE;
    endcase

    // Edges arriving while a request is outstanding are queued; a set of the
    // overflow flag overrides a same-cycle clear by completion.
    if (le_i && rise && (state_q != GW_IDLE)) begin
      if (cnt_q == CntMax) ovf_d = 1'b1;
      else                 cnt_d = cnt_q + CntOne;
    end

    if (!le_i) cnt_d = '0;
  end

  // Output logic: ip is the registered decode of the next state, so it always
  // equals (state == PENDING) without any combinational input-to-output path.
  always_comb begin
    ip_d = (state_d == GW_PENDING);
  end

  assign ip_o       = ip_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/irq_gateway_array.sv
// -----------------------------------------------------------------------------
// irq_gateway_array
//   Bank of interrupt gateways between SoC interrupt wires and the PLIC core.
//   Decodes claim/complete IDs into one-hot hits and instantiates one
//   irq_gateway_cell per source. Source bit k carries interrupt ID k+1.
// Ports
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   irq_sources_i    raw interrupt wires
//   le_i             per-source trigger mode (1 = edge, 0 = level)
//   ip_o             registered pending vector to the PLIC core
//   claim_valid_i    claim strobe, claim_id_i = claimed ID
//   complete_valid_i completion strobe, complete_id_i = completed ID
//   overflow_o       sticky per-source edge-counter overflow
// -----------------------------------------------------------------------------
module irq_gateway_array
  import irq_gateway_pkg::*;
#(
  parameter int unsigned NumSources   = 30,
  parameter int unsigned EdgeCntWidth = 4,
  parameter int unsigned SyncStages   = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumSources-1:0]           irq_sources_i,
  input  logic [NumSources-1:0]           le_i,
  output logic [NumSources-1:0]           ip_o,
  input  logic                            claim_valid_i,
  input  logic [id_width(NumSources)-1:0] claim_id_i,
  input  logic                            complete_valid_i,
  input  logic [id_width(NumSources)-1:0] complete_id_i,
  output logic [NumSources-1:0]           overflow_o
);

  localparam int unsigned IdWidth = id_width(NumSources);
  typedef logic [IdWidth-1:0] id_t;

  logic [NumSources-1:0] claim_hit;
  logic [NumSources-1:0] complete_hit;

  // ID 0 and IDs above NumSources match no cell and are therefore ignored.
  for (genvar k = 0; k < NumSources; k++) begin : g_cell
    assign claim_hit[k]    = claim_valid_i    && (claim_id_i    == id_t'(k + 1));
    assign complete_hit[k] = complete_valid_i && (complete_id_i == id_t'(k + 1));

    irq_gateway_cell #(
      .EdgeCntWidth (EdgeCntWidth),
      .SyncStages   (SyncStages)
    ) u_cell (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .src_i          (irq_sources_i[k]),
      .le_i           (le_i[k]),
      .claim_hit_i    (claim_hit[k]),
      .complete_hit_i (complete_hit[k]),
      .ip_o           (ip_o[k]),
      .overflow_o     (overflow_o[k])
    );
  end

endmodule

// File: tb/tb_irq_gateway_array.sv
// -----------------------------------------------------------------------------
// tb_irq_gateway_array
//   Directed scenarios followed by randomized traffic; every cycle the DUT's
//   ip_o / overflow_o are compared with a behavioural model of the gateways.
// -----------------------------------------------------------------------------
module tb_irq_gateway_array;

  localparam int N    = 30;
  localparam int CW   = 4;
  localparam int SS   = 2;
  localparam int IW   = $clog2(N + 1);
  localparam int CMAX = (1 << CW) - 1;

  typedef logic [IW-1:0] id_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  irq_sources_i;
  logic [N-1:0]  le_i;
  logic [N-1:0]  ip_o;
  logic          claim_valid_i;
  id_t           claim_id_i;
  logic          complete_valid_i;
  id_t           complete_id_i;
  logic [N-1:0]  overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  irq_gateway_array #(
    .NumSources   (N),
    .EdgeCntWidth (CW),
    .SyncStages   (SS)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .irq_sources_i    (irq_sources_i),
    .le_i             (le_i),
    .ip_o             (ip_o),
    .claim_valid_i    (claim_valid_i),
    .claim_id_i       (claim_id_i),
    .complete_valid_i (complete_valid_i),
    .complete_id_i    (complete_id_i),
    .overflow_o       (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Reference model: raw wire history as a delay line, per-source request
  // flags and an integer backlog of queued edges.
  // ---------------------------------------------------------------------------
  logic [N-1:0] m_hist [SS+1];  // m_hist[i] = wire value sampled i+1 edges ago
  bit           m_pend [N];
  bit           m_busy [N];
  int           m_backlog [N];
  bit           m_ovf [N];

  function automatic logic [N-1:0] m_ip_vec();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_pend[k];
    return v;
  endfunction

  function automatic logic [N-1:0] m_ovf_vec();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_ovf[k];
    return v;
  endfunction

  task automatic model_step();
    logic [N-1:0] seen;
    logic [N-1:0] prev;
    bit           rise;
    bit           was_out;
    seen = m_hist[SS-1];
    prev = m_hist[SS];
    if (rst_i) begin
      for (int i = 0; i <= SS; i++) m_hist[i] = '0;
      for (int k = 0; k < N; k++) begin
        m_pend[k] = 0; m_busy[k] = 0; m_backlog[k] = 0; m_ovf[k] = 0;
      end
      return;
    end
    for (int k = 0; k < N; k++) begin
      rise    = seen[k] && !prev[k];
      was_out = m_pend[k] || m_busy[k];
      if (!was_out) begin
        if (le_i[k]) begin
          if (rise || m_backlog[k] > 0) m_pend[k] = 1;
          if (m_backlog[k] > 0 && !rise) m_backlog[k]--;
        end else if (seen[k]) begin
          m_pend[k] = 1;
        end
      end else if (m_pend[k]) begin
        if (claim_valid_i && int'(claim_id_i) == k + 1) begin
          m_pend[k] = 0; m_busy[k] = 1;
        end
      end else begin
        if (complete_valid_i && int'(complete_id_i) == k + 1) begin
          m_busy[k] = 0; m_ovf[k] = 0;
        end
      end
      if (le_i[k] && rise && was_out) begin
        if (m_backlog[k] == CMAX) m_ovf[k] = 1;
        else                      m_backlog[k]++;
      end
      if (!le_i[k]) m_backlog[k] = 0;
    end
    for (int i = SS; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = irq_sources_i;
  endtask

  // ---------------------------------------------------------------------------
  // Checking and stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare the registered outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    check("ip_o vs model", 64'(ip_o), 64'(m_ip_vec()));
    check("overflow_o vs model", 64'(overflow_o), 64'(m_ovf_vec()));
  endtask

  task automatic claim(input int id);
    claim_valid_i = 1'b1; claim_id_i = id_t'(id);
    tick();
    claim_valid_i = 1'b0; claim_id_i = '0;
  endtask

  task automatic complete(input int id);
    complete_valid_i = 1'b1; complete_id_i = id_t'(id);
    tick();
    complete_valid_i = 1'b0; complete_id_i = '0;
  endtask

  task automatic pulse(input int bit_idx, input int count);
    for (int i = 0; i < count; i++) begin
      irq_sources_i[bit_idx] = 1'b1; tick();
      irq_sources_i[bit_idx] = 1'b0; tick();
    end
  endtask

  function automatic id_t pick_id(input bit want_busy);
    int q[$];
    for (int k = 0; k < N; k++)
      if (want_busy ? m_busy[k] : m_pend[k]) q.push_back(k + 1);
    if (q.size() == 0 || $urandom_range(0, 1) == 0) return id_t'($urandom_range(0, 31));
    return id_t'(q[$urandom_range(0, q.size() - 1)]);
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i <= SS; i++) m_hist[i] = '0;
    rst_i = 1'b1; irq_sources_i = '0; le_i = '0;
    claim_valid_i = 1'b0; claim_id_i = '0;
    complete_valid_i = 1'b0; complete_id_i = '0;

    // Reset state
    tick(); tick();
    check("reset ip_o", 64'(ip_o), 64'h0);
    check("reset overflow_o", 64'(overflow_o), 64'h0);
    rst_i = 1'b0;

    // Level mode, source bit 3 = ID 4
    irq_sources_i[3] = 1'b1;
    tick(); tick();
    check("level before latency", 64'(ip_o[3]), 64'd0);
    tick();
    check("level at latency", 64'(ip_o[3]), 64'd1);
    claim(4);
    check("level after claim", 64'(ip_o[3]), 64'd0);
    tick(); tick();
    complete(4);
    check("level at complete", 64'(ip_o[3]), 64'd0);
    tick();
    check("level re-raise", 64'(ip_o[3]), 64'd1);
    claim(4);
    irq_sources_i[3] = 1'b0;
    repeat (4) tick();
    complete(4);
    repeat (3) tick();
    check("level quiet after drop", 64'(ip_o[3]), 64'd0);

    // Edge burst, source bit 1 = ID 2
    le_i[1] = 1'b1;
    pulse(1, 1);
    tick();
    check("edge first request", 64'(ip_o[1]), 64'd1);
    claim(2);
    pulse(1, 5);
    repeat (4) tick();
    for (int r = 0; r < 5; r++) begin
      complete(2);
      tick();
      check("edge burst round", 64'(ip_o[1]), 64'd1);
      claim(2);
    end
    complete(2);
    tick(); tick();
    check("edge burst drained", 64'(ip_o[1]), 64'd0);
    check("edge burst no overflow", 64'(overflow_o[1]), 64'd0);

    // Counter saturation
    pulse(1, 1);
    tick();
    claim(2);
    pulse(1, 17);
    repeat (4) tick();
    check("saturation overflow set", 64'(overflow_o[1]), 64'd1);
    complete(2);
    check("saturation overflow cleared", 64'(overflow_o[1]), 64'd0);

    // Reset mid-operation: ID 2 in flight with backlog and overflow, ID 4 in flight
    tick();
    claim(2);
    pulse(1, 3);
    repeat (4) tick();
    check("pre-reset overflow", 64'(overflow_o[1]), 64'd1);
    irq_sources_i[3] = 1'b1;
    repeat (3) tick();
    claim(4);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid reset ip_o", 64'(ip_o), 64'h0);
    check("mid reset overflow_o", 64'(overflow_o), 64'h0);
    tick(); tick();
    check("post reset level early", 64'(ip_o[3]), 64'd0);
    tick();
    check("post reset level re-pend", 64'(ip_o[3]), 64'd1);
    check("post reset backlog cleared", 64'(ip_o[1]), 64'd0);

    // Bad IDs: only ID 4 is pending
    claim(0);
    check("claim id 0 ignored", 64'(ip_o), 64'h8);
    claim(31);
    check("claim id 31 ignored", 64'(ip_o), 64'h8);
    claim(5);
    check("claim idle id ignored", 64'(ip_o), 64'h8);
    complete(4);
    check("complete pending id ignored", 64'(ip_o), 64'h8);

    // Simultaneous claim of ID 2 and completion of ID 1
    le_i[0] = 1'b1;
    irq_sources_i[0] = 1'b1; irq_sources_i[1] = 1'b1; tick();
    irq_sources_i[0] = 1'b0; irq_sources_i[1] = 1'b0; tick(); tick();
    check("both edge ids pending", 64'(ip_o), 64'hB);
    claim(1);
    claim_valid_i = 1'b1; claim_id_i = id_t'(2);
    complete_valid_i = 1'b1; complete_id_i = id_t'(1);
    tick();
    claim_valid_i = 1'b0; complete_valid_i = 1'b0;
    check("simultaneous ip_o", 64'(ip_o), 64'h8);
    claim(1);
    complete(2);
    tick();
    check("id2 completed after simultaneous", 64'(ip_o), 64'h8);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) irq_sources_i[k] = ~irq_sources_i[k];
      if ($urandom_range(0, 63) == 0) le_i = N'($urandom);
      claim_valid_i    = ($urandom_range(0, 2) == 0);
      claim_id_i       = pick_id(1'b0);
      complete_valid_i = ($urandom_range(0, 2) == 0);
      complete_id_i    = pick_id(1'b1);
      tick();
    end
    rst_i = 1'b0; claim_valid_i = 1'b0; complete_valid_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
